grid_display_scan: RTL
======================

GRID_DISPLAY_SCAN -- requirements
Module: grid_display_scan

Interface
REQ-001 Parameter DWELL, default 4, clock cycles each row is driven; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  high = scanning runs; low = scan frozen, display blanked.
REQ-005 grid_in  input  64  board from the life-update stage; row r = grid_in[8r+7:8r], row 0 = [7:0].
REQ-006 grid_valid  input  1  grid_in holds a new generation.
REQ-007 grid_ready  output  1  block can accept a generation; transfer = grid_valid && grid_ready at a rising edge.
REQ-008 row_sel  output  8  one-hot active-high row strobe; 8'h00 = blank.
REQ-009 col_data  output  8  column bits of the driven row; 8'h00 when blank.
REQ-010 frame_done  output  1  one-cycle pulse per completed 8-row scan.
REQ-011 stable  output  1  last displayed generation equals its predecessor.
REQ-012 extinct  output  1  displayed generation is all zero.
REQ-013 gen_count  output  16  accepted generations, saturating at 16'hFFFF.

Function
REQ-014 Two 64-bit registers: shadow (pending) and active (displayed); pending flag marks shadow full.
REQ-015 grid_ready = !pending, combinational from the flag.
REQ-016 Accepted transfer sets pending and captures grid_in into shadow on that edge; gen_count increments on the same edge unless at 16'hFFFF.
REQ-017 States: IDLE (no active frame), SCAN. IDLE with pending -> SCAN on next edge, shadow copied to active, pending cleared, row 0, dwell 0.
REQ-018 In SCAN with enable high, row r drives row_sel = 1<<r and col_data = active[8r+7:8r] for DWELL cycles, then row r+1; row 7 wraps to row 0.
REQ-019 Frame end = edge leaving row 7's last dwell cycle; frame_done is high for exactly the following cycle (row 0's first cycle).
REQ-020 At frame end, if pending: shadow -> active, pending cleared (grid_ready high next cycle); otherwise active is rescanned unchanged.
REQ-021 On every shadow->active copy: stable <= (shadow == old active) when active was previously loaded, else 0; extinct <= (shadow == 64'h0).
REQ-022 grid_valid at the frame-end edge while pending: not accepted (grid_ready low); while not pending: captured into shadow only, displayed next frame.
REQ-023 enable low: row/dwell counters hold, row_sel = 8'h00, col_data = 8'h00, no frame_done; handshake, shadow, gen_count keep working; scan resumes from the held position when enable rises.
REQ-024 Outputs row_sel, col_data, frame_done, stable, extinct registered; no combinational path grid_in -> outputs.

Reset
REQ-025 reset low: state IDLE, pending 0, shadow/active 64'h0, row 0, dwell 0, row_sel 8'h00, col_data 8'h00, frame_done 0, stable 0, extinct 0, gen_count 0.
REQ-026 Reset mid-frame abandons the scan and discards any pending generation; first post-reset acceptance restarts from IDLE.

Structure
REQ-027 Package grid_pkg holds ROWS=8, COLS=8, grid_t (64-bit board typedef), row_t (8-bit), and the scan-state enum {IDLE, SCAN}.
REQ-028 One sub-module, dwell_counter: DWELL-cycle counter with enable, emitting a terminal-count strobe that advances the row.

Verification (DWELL=4, frame = 32 cycles)
REQ-029 Reset then grid_in=64'h0412_6424_0034_3C28 pulsed valid -> SCAN two edges later; row 0 col_data=8'h28 for 4 cycles, row 1 8'h3C, ..., row 7 8'h04; frame_done one cycle after row 7; gen_count=1.
REQ-030 Second valid mid-frame with same value -> grid_ready low until frame end; at frame end stable=1, extinct=0; third valid while pending ignored, gen_count=2.
REQ-031 Valid with 64'h0 -> after frame end all col_data=8'h00, extinct=1, stable=0.
REQ-032 enable low for 10 cycles during row 3 -> row_sel=8'h00 for those cycles; row 3 resumes with its remaining dwell; frame_done delayed by 10 cycles.
REQ-033 Reset asserted during row 5 with pending set -> all outputs zero asynchronously; after release, no scan until a new valid.
REQ-034 Force gen_count to 16'hFFFE, two accepted transfers -> gen_count holds at 16'hFFFF.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared types for the life-grid display scanner: board/row typedefs,
// scan-state encoding and row extraction helpers.
package grid_pkg;
   localparam int ROWS = 8;
   localparam int COLS = 8;

   typedef logic [ROWS*COLS-1:0] grid_t;
   typedef logic [COLS-1:0]      row_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_e;

   function automatic row_t grid_row(input grid_t g, input logic [2:0] r);
      return g[{r, 3'b000} +: COLS];
   endfunction

   function automatic row_t row_onehot(input logic [2:0] r);
      return row_t'(1) << r;
   endfunction
endpackage

// File: rtl/dwell_counter.sv
// Per-row dwell timer: down-counter reloaded with DWELL-1, strobes o_tc on the
// last enabled cycle of a row so the scanner can advance.
module dwell_counter #(
   parameter int unsigned DWELL = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);
   localparam logic [7:0] LOAD = 8'(DWELL - 1);

   logic [7:0] r_remain;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_remain <= LOAD;
      end else if (i_clr) begin
         r_remain <= LOAD;
      end else if (i_en) begin
         r_remain <= (r_remain == 8'd0) ? LOAD : r_remain - 8'd1;
      end
   end

   assign o_tc = i_en && (r_remain == 8'd0);
endmodule

// File: rtl/grid_display_scan.sv
// Double-buffered 8x8 LED matrix scanner: accepts generations into a shadow
// board and swaps them into the displayed board only on frame boundaries.
//
// state | meaning
// IDLE  | no board loaded yet; waits for the first pending generation
// SCAN  | rows driven in turn, DWELL cycles each, while enable is high
module grid_display_scan
   import grid_pkg::*;
#(
   parameter int unsigned DWELL = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_enable,
   input  grid_t       i_grid_in,
   input  logic        i_grid_valid,
   output logic        o_grid_ready,
   output row_t        o_row_sel,
   output row_t        o_col_data,
   output logic        o_frame_done,
   output logic        o_stable,
   output logic        o_extinct,
   output logic [15:0] o_gen_count
);
   scan_state_e r_state;
   grid_t       r_shadow;
   grid_t       r_active;
   logic        r_pending;
   logic        r_loaded;
   logic [2:0]  r_row;
   row_t        r_row_sel;
   row_t        r_col_data;
   logic        r_frame_done;
   logic        r_stable;
   logic        r_extinct;
   logic [15:0] r_gen_count;

   logic        w_accept;
   logic        w_start;
   logic        w_run;
   logic        w_tc;
   logic        w_frame_end;
   logic        w_load;
   logic        w_show;
   logic [2:0]  w_row_nxt;
   grid_t       w_active_nxt;
   logic [15:0] w_gen_nxt;

   dwell_counter #(.DWELL(DWELL)) u_dwell (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (w_start),
      .i_en    (w_run),
      .o_tc    (w_tc)
   );

   assign w_accept     = i_grid_valid && !r_pending;
   assign w_start      = (r_state == IDLE) && r_pending;
   assign w_run        = (r_state == SCAN) && i_enable;
   assign w_frame_end  = w_tc && (r_row == 3'd7);
   assign w_load       = w_start || (w_frame_end && r_pending);
   assign w_row_nxt    = w_start ? 3'd0 : (w_tc ? r_row + 3'd1 : r_row);
   assign w_active_nxt = w_load ? r_shadow : r_active;
   assign w_show       = (w_start || (r_state == SCAN)) && i_enable;
   assign w_gen_nxt    = (w_accept && (r_gen_count != 16'hFFFF)) ? r_gen_count + 16'd1
                                                                 : r_gen_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_shadow     <= '0;
         r_active     <= '0;
         r_pending    <= 1'b0;
         r_loaded     <= 1'b0;
         r_row        <= 3'd0;
         r_row_sel    <= '0;
         r_col_data   <= '0;
         r_frame_done <= 1'b0;
         r_stable     <= 1'b0;
         r_extinct    <= 1'b0;
         r_gen_count  <= 16'd0;
      end else begin
         // accept and load are exclusive: one needs pending clear, the other set
         if (w_accept) begin
            r_shadow  <= i_grid_in;
            r_pending <= 1'b1;
         end else if (w_load) begin
            r_pending <= 1'b0;
         end
         if (w_start) begin
            r_state <= SCAN;
         end
         if (w_load) begin
            r_stable  <= r_loaded && (r_shadow == r_active);
            r_extinct <= (r_shadow == '0);
            r_loaded  <= 1'b1;
         end
         r_row        <= w_row_nxt;
         r_active     <= w_active_nxt;
         r_gen_count  <= w_gen_nxt;
         r_frame_done <= w_frame_end;
         r_row_sel    <= w_show ? row_onehot(w_row_nxt) : '0;
         r_col_data   <= w_show ? grid_row(w_active_nxt, w_row_nxt) : '0;
      end
   end

   assign o_grid_ready = !r_pending;
   assign o_row_sel    = r_row_sel;
   assign o_col_data   = r_col_data;
   assign o_frame_done = r_frame_done;
   assign o_stable     = r_stable;
   assign o_extinct    = r_extinct;
   assign o_gen_count  = r_gen_count;
endmodule
